// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution frame writer.
// Holds the capture FSM encoding, the warm-up border width and counter sizing.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DRAIN
    } state_e;

    localparam int BORDER         = 2;
    localparam int DEF_WIDTH      = 640;
    localparam int DEF_HEIGHT     = 480;
    localparam int DEF_DATA_W     = 12;
    localparam int DEF_ADDR_W     = 19;
    localparam int DEF_FIFO_DEPTH = 16;

    // Bits needed to index 0..n-1; never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_frame_writer_if.sv
// Pixel-stream input and frame-store write port of the frame writer.
// The master modport is the writer itself; slave is the surrounding environment.
interface conv_frame_writer_if
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [DATA_W-1:0] iDATA;
    logic              iDVAL;
    logic              iSTART;
    logic              oWR_REQ;
    logic [ADDR_W-1:0] oWR_ADDR;
    logic [DATA_W-1:0] oWR_DATA;
    logic              iWR_ACK;
    logic              oBUSY;
    logic              oDONE;
    logic              oOVERFLOW;

    modport master (
        input  iDATA, iDVAL, iSTART, iWR_ACK,
        output oWR_REQ, oWR_ADDR, oWR_DATA, oBUSY, oDONE, oOVERFLOW
    );

    modport slave (
        output iDATA, iDVAL, iSTART, iWR_ACK,
        input  oWR_REQ, oWR_ADDR, oWR_DATA, oBUSY, oDONE, oOVERFLOW
    );
endinterface

// File: rtl/conv_frame_writer_fifo.sv
// Show-ahead FIFO with a registered head word, so dout never depends on push/pop
// in the current cycle. Push on a full FIFO is accepted only if a pop happens too.
module pix_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = cnt_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = dout_q;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        dout_d   = dout_q;
        if ((count_q - CW'(do_pop)) != '0) begin
            dout_d = mem[rd_ptr_d];
        end else if (do_push) begin
            dout_d = din;
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/conv_frame_writer.sv
// Captures one raster frame from the filter stream, blanks the warm-up border and
// queues one addressed write per pixel towards the frame store.
module conv_frame_writer
    import conv_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic         iCLK,
    input  logic         iRST,
    conv_frame_writer_if.master bus
);
    localparam int XW = cnt_w(WIDTH);
    localparam int YW = cnt_w(HEIGHT);
    localparam int EW = ADDR_W + DATA_W;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;

    logic              accept, pop, last_x, last_px;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] pix_data;
    logic [EW-1:0]     push_entry, head;

    assign accept   = bus.iDVAL && (state_q == ST_ARMED || state_q == ST_CAPTURE);
    assign pop      = !fifo_empty && bus.iWR_ACK;
    assign last_x   = (x_q == XW'(WIDTH - 1));
    assign last_px  = last_x && (y_q == YW'(HEIGHT - 1));
    // The first BORDER rows and columns are filter warm-up and carry no real pixel.
    assign pix_data = (int'(x_q) < BORDER || int'(y_q) < BORDER) ? '0 : bus.iDATA;
    assign push_entry = {base_q + ADDR_W'(x_q), pix_data};

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (iCLK),
        .rst   (iRST),
        .push  (accept),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        base_d     = base_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.iSTART) begin
                    state_d    = ST_ARMED;
                    x_d        = '0;
                    y_d        = '0;
                    base_d     = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_ARMED, ST_CAPTURE: begin
                if (accept) begin
                    if (fifo_full && !pop) begin
                        overflow_d = 1'b1;
                    end
                    state_d = last_px ? ST_DRAIN : ST_CAPTURE;
                    // Counters advance even on a dropped pixel to keep later addresses aligned.
                    if (last_x) begin
                        x_d    = '0;
                        y_d    = y_q + 1'b1;
                        base_d = base_q + ADDR_W'(WIDTH);
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            base_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            base_q     <= base_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign bus.oWR_REQ   = !fifo_empty;
    assign bus.oWR_ADDR  = head[EW-1:DATA_W];
    assign bus.oWR_DATA  = head[DATA_W-1:0];
    assign bus.oBUSY     = (state_q != ST_IDLE);
    assign bus.oDONE     = done_q;
    assign bus.oOVERFLOW = overflow_q;

endmodule

// File: tb/tb_conv_frame_writer.sv
// Randomized bench for conv_frame_writer on a 4x3 frame with a 4-entry buffer,
// compared every cycle against a queue-based model of frame capture and writes.
module tb_conv_frame_writer;
    import conv_pkg::*;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 12;
    localparam int AW = 4;
    localparam int D  = 4;
    localparam int N  = W * H;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_frame_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    conv_frame_writer #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (D)
    ) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    wr_t wlog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frame is a linear pixel index n; x = n % W, y = n / W; buffer is a bounded queue.
    wr_t mq[$];
    int  m_state = 0; // 0 idle, 1 capturing, 2 draining
    int  m_n     = 0;
    bit  m_done  = 1'b0;
    bit  m_ovf   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_state = 0;
            m_n     = 0;
            m_done  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            int  pre;
            bit  popped;
            wr_t e;
            pre    = mq.size();
            popped = (pre > 0) && bus.iWR_ACK;
            m_done = 1'b0;
            if (popped) void'(mq.pop_front());
            case (m_state)
                0: if (bus.iSTART) begin
                    m_state = 1;
                    m_n     = 0;
                    m_ovf   = 1'b0;
                end
                1: if (bus.iDVAL) begin
                    e.addr = AW'(m_n);
                    e.data = ((m_n % W) < BORDER || (m_n / W) < BORDER) ? '0 : bus.iDATA;
                    if (mq.size() < D) mq.push_back(e);
                    else m_ovf = 1'b1;
                    m_n++;
                    if (m_n == N) m_state = 2;
                end
                2: if (pre == 0) begin
                    m_state = 0;
                    m_done  = 1'b1;
                end
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("req", bus.oWR_REQ, mq.size() != 0);
        if (mq.size() != 0) begin
            check("addr", bus.oWR_ADDR, mq[0].addr);
            check("data", bus.oWR_DATA, mq[0].data);
        end
        check("busy", bus.oBUSY, m_state != 0);
        check("done", bus.oDONE, m_done);
        check("overflow", bus.oOVERFLOW, m_ovf);
        if (bus.oWR_REQ === 1'b1 && bus.iWR_ACK === 1'b1)
            wlog.push_back('{addr: bus.oWR_ADDR, data: bus.oWR_DATA});
        if (bus.oDONE === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        wlog.delete();
        bus.iSTART = 1'b1;
        tick();
        bus.iSTART = 1'b0;
    endtask

    task automatic send_px(input logic [DW-1:0] d);
        bus.iDVAL = 1'b1;
        bus.iDATA = d;
        tick();
        bus.iDVAL = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int base;
        int k;
        base = done_cnt;
        k = 0;
        bus.iDVAL = 1'b0;
        while (done_cnt == base && k < 200) begin
            tick();
            k++;
        end
        repeat (3) tick();
        check({name, "_done_once"}, done_cnt - base, 1);
    endtask

    task automatic check_order(input string name, input int n);
        check({name, "_nwrites"}, wlog.size(), n);
        for (int i = 0; i < wlog.size(); i++)
            check($sformatf("%s_addr%0d", name, i), wlog[i].addr, i);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req"},  bus.oWR_REQ, 0);
        check({name, "_addr"}, bus.oWR_ADDR, 0);
        check({name, "_data"}, bus.oWR_DATA, 0);
        check({name, "_busy"}, bus.oBUSY, 0);
        check({name, "_done"}, bus.oDONE, 0);
        check({name, "_ovf"},  bus.oOVERFLOW, 0);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.iDATA   = '0;
        bus.iDVAL   = 1'b0;
        bus.iSTART  = 1'b0;
        bus.iWR_ACK = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Full frame, always acknowledged.
        bus.iWR_ACK = 1'b1;
        start_frame();
        for (int i = 0; i < N; i++) send_px(DW'(100 + i));
        wait_done("t1");
        check_order("t1", N);
        for (int i = 0; i < wlog.size(); i++)
            check($sformatf("t1_data%0d", i), wlog[i].data, (i >= 10) ? 100 + i : 0);
        check("t1_ovf", bus.oOVERFLOW, 0);

        // Stalled memory: only the first D pixels survive.
        bus.iWR_ACK = 1'b0;
        start_frame();
        for (int i = 0; i < N; i++) send_px(DW'($urandom));
        repeat (7) tick();
        check("t2_ovf_sticky", bus.oOVERFLOW, 1);
        bus.iWR_ACK = 1'b1;
        wait_done("t2");
        check_order("t2", D);
        for (int i = 0; i < wlog.size(); i++)
            check($sformatf("t2_data%0d", i), wlog[i].data, 0);
        check("t2_ovf_after", bus.oOVERFLOW, 1);

        // Gapped input, random acknowledge; pixel cycles always ack so the buffer cannot fill.
        start_frame();
        for (int i = 0; i < N; i++) begin
            bus.iWR_ACK = 1'b1;
            send_px(DW'($urandom));
            repeat (2) begin
                bus.iWR_ACK = ($urandom_range(0, 1) == 1);
                tick();
            end
        end
        bus.iWR_ACK = 1'b1;
        wait_done("t3");
        check_order("t3", N);
        check("t3_ovf", bus.oOVERFLOW, 0);

        // Stray valids in idle, while armed-and-waiting, and during drain.
        bus.iWR_ACK = 1'b1;
        repeat (3) send_px(DW'($urandom));
        bus.iDVAL = 1'b1;
        start_frame();
        bus.iDVAL = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < N - 1; i++) send_px(DW'($urandom));
        bus.iWR_ACK = 1'b0;
        send_px(DW'($urandom));
        bus.iDVAL = 1'b1;
        repeat (3) tick();
        bus.iDVAL = 1'b0;
        bus.iWR_ACK = 1'b1;
        wait_done("t4");
        check_order("t4", N);

        // Reset in the middle of a frame.
        bus.iWR_ACK = 1'b1;
        start_frame();
        repeat (2) send_px(DW'($urandom));
        bus.iWR_ACK = 1'b0;
        repeat (3) send_px(DW'($urandom));
        check("t5_req_before", bus.oWR_REQ, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        bus.iWR_ACK = 1'b1;
        start_frame();
        for (int i = 0; i < N; i++) send_px(DW'($urandom));
        wait_done("t5");
        check_order("t5", N);

        // Full buffer with simultaneous push and pop.
        bus.iWR_ACK = 1'b0;
        start_frame();
        for (int i = 0; i < D; i++) send_px(DW'($urandom));
        bus.iWR_ACK = 1'b1;
        send_px(DW'($urandom));
        bus.iWR_ACK = 1'b0;
        tick();
        check("t6_ovf", bus.oOVERFLOW, 0);
        check("t6_req", bus.oWR_REQ, 1);
        check("t6_head", bus.oWR_ADDR, 1);
        bus.iWR_ACK = 1'b1;
        for (int i = D + 1; i < N; i++) send_px(DW'($urandom));
        wait_done("t6");
        check_order("t6", N);
        check("t6_ovf_end", bus.oOVERFLOW, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_frame_writer.md
# conv_frame_writer

Stream-to-memory sink for the edge-filter pipeline output. Consumes the 12-bit filtered pixel stream and its valid strobe, and tracks raster position. Zeroes the window-warm-up border. Buffers pixels in a small FIFO and issues one addressed write per pixel over a req/ack port into the frame store. Sits directly after the convolution stage and before the frame-buffer arbiter.

## Interface
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- DATA_W, 12, pixel width
- ADDR_W, 19, write address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT
- FIFO_DEPTH, 16, write buffer entries, power of two
- iCLK  in  1  single clock, rising edge
- iRST  in  1  reset, asynchronous, active-high
- iDATA  in  DATA_W  filtered pixel
- iDVAL  in  1  iDATA valid this cycle; no backpressure upstream
- iSTART  in  1  arm capture of one frame (level sampled per cycle)
- oWR_REQ  out  1  write request; FIFO head valid
- oWR_ADDR  out  ADDR_W  linear pixel address
- oWR_DATA  out  DATA_W  pixel to write
- iWR_ACK  in  1  memory accepted head this cycle
- oBUSY  out  1  high in any state other than IDLE
- oDONE  out  1  one-cycle pulse when a frame is fully written
- oOVERFLOW  out  1  sticky; a pixel was dropped on a full FIFO

## Operation
- FSM states: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE → ARMED on iSTART=1; clears oOVERFLOW and the x/y counters.
- ARMED → CAPTURE on the first iDVAL=1. That sample is raster (0,0) and is accepted in the same cycle.
- CAPTURE: each iDVAL=1 accepts one sample at (x,y).
  - x wraps at WIDTH-1 to 0 with y+1.
  - After the sample at (WIDTH-1, HEIGHT-1) is accepted, go to DRAIN.
- DRAIN → IDLE when the FIFO is empty and no write is outstanding. oDONE pulses on that transition.
- iSTART is ignored outside IDLE.
- Per accepted sample:
  - address = y*WIDTH + x, computed from counters, no multiplier.
  - data = 0 if x<2 or y<2, else iDATA.
- FIFO push = accepted sample. Pop = oWR_REQ & iWR_ACK.
- Full FIFO with a push and no pop:
  - sample dropped; oOVERFLOW set.
  - x/y still advance so later addresses stay raster-correct.
- Full FIFO with simultaneous push and pop: both take effect; no drop.
- Empty FIFO: oWR_REQ=0. oWR_ADDR/oWR_DATA hold their last values and are don't-care.
- oWR_REQ/oWR_ADDR/oWR_DATA stay stable while oWR_REQ=1 and iWR_ACK=0.
- iWR_ACK while oWR_REQ=0 is ignored.
- iDVAL in IDLE or DRAIN is ignored and not counted.

## Timing
- Reset values: state IDLE, FIFO empty, counters 0. oWR_REQ=0, oWR_ADDR=0, oWR_DATA=0, oBUSY=0, oDONE=0, oOVERFLOW=0.
- iRST mid-frame aborts immediately: FIFO contents discarded, no oDONE.
- Push-to-request latency is 1 cycle: sample accepted at edge N gives oWR_REQ=1 after edge N if the FIFO was empty.
- Back-to-back acks drain one entry per cycle.
- oBUSY rises the cycle after iSTART is sampled in IDLE. It falls in the same cycle oDONE is high.
- All outputs are registered or decoded directly from registered FIFO/FSM state; no combinational path from iDVAL or iWR_ACK to outputs.

## Structure
- Shared package `conv_pkg`:
  - FSM state enum (IDLE/ARMED/CAPTURE/DRAIN).
  - Border constant BORDER=2.
  - Default WIDTH/HEIGHT/DATA_W.
- Sub-module `pix_fifo`: synchronous show-ahead FIFO of {addr,data}.
  - Parameters: depth, width. Outputs: full/empty.
  - Simultaneous push+pop allowed when full.
- Address generator: running line-base register (+WIDTH per line) plus x.

## Test plan
- WIDTH=4, HEIGHT=3, iWR_ACK tied 1, iSTART then 12 consecutive iDVAL pixels 100..111 → writes addr 0..11, data 0 except addr 10→110, 11→111; oDONE pulses once; oOVERFLOW=0.
- iWR_ACK=0 for 20 cycles during a 12-pixel frame with FIFO_DEPTH=4 → first 4 entries held stable, later pixels dropped, oOVERFLOW=1. After ack resumes, addresses of the written entries remain raster-correct; oDONE pulses.
- Gapped iDVAL (1 of every 3 cycles) with random iWR_ACK → exactly WIDTH*HEIGHT writes, in address order, with correct data.
- iDVAL pulses before iSTART and during DRAIN → not written; frame still starts at addr 0 on the first iDVAL after ARMED.
- Assert iRST after 5 accepted pixels → all outputs reset values next cycle; a new iSTART frame writes addr 0..11 correctly.
- FIFO full, push and ack in the same cycle → no drop, oOVERFLOW stays 0, occupancy unchanged.
